link_fault_injector: RTL and testbench
======================================

// Module: link_fault_injector
// PURPOSE
//  Parametrised, deterministic fault injector on one credit-based NoC link (tx side -> rx side), simulation only.
//  Forwards packets and, after a pseudo-random packet gap, attacks one packet: HANG (stall), DROP (swallow) or CORRUPT (XOR payload).
//  Selects attack mode at run time; a 16-bit seeded LFSR makes every run reproducible.
//  Instantiated per router port in the sim top.
// PARAMETERS
//  FLIT_WIDTH      32       data flit width
//  ADDRESS         16'h0    router address {x,y}, used in $display only
//  PORT            ""       port name string, used in $display only
//  SEED            16'hACE1 LFSR reset value (must be nonzero)
//  GAP_MIN         5        minimum packets forwarded between attacks (>=0)
//  GAP_SPAN_LOG2   2        gap = GAP_MIN + (lfsr[7:0] & (2^GAP_SPAN_LOG2-1)), span <=8
//  HANG_MIN        16       minimum HANG-state cycles (>=1)
//  HANG_SPAN_LOG2  4        hang = HANG_MIN + (lfsr[15:8] & (2^HANG_SPAN_LOG2-1)), span <=8
//  CORRUPT_MASK    all-1s   [FLIT_WIDTH-1:0] XOR mask applied in CORRUPT
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           reset, asynchronous, active-low
//  enable_i       in   1           attacks allowed; 0 = pure passthrough
//  mode_i         in   2           0 none, 1 HANG, 2 DROP, 3 CORRUPT (sampled in IDLE only)
//  tx_i           in   1           upstream flit valid
//  data_tx_i      in   FLIT_WIDTH  upstream flit data
//  eop_tx_i       in   1           upstream end-of-packet
//  cr_tx_o        out  1           credit to upstream
//  rx_o           out  1           downstream flit valid
//  data_rx_o      out  FLIT_WIDTH  downstream flit data
//  eop_rx_o       out  1           downstream end-of-packet
//  cr_rx_i        in   1           credit from downstream
//  attack_o       out  1           1 while state in {HANG, DROP, CORRUPT}
//  attack_cnt_o   out  16          attacks launched, saturates at 16'hFFFF
// BEHAVIOUR
//  Transfer (fwd) = tx_i & cr_rx_i; EOP handshake = fwd & eop_tx_i. Outputs are combinational from state and inputs, zero latency.
//  Passthrough: rx_o=tx_i, data_rx_o=data_tx_i, eop_rx_o=eop_tx_i, cr_tx_o=cr_rx_i.
//  Reset: state IDLE, gap_cnt=GAP_MIN, lfsr=SEED, attack_cnt_o=0, attack_o=0; outputs passthrough immediately, also mid-attack.
//  launch = IDLE & tx_i & enable_i & mode_i!=0 & gap_cnt==0. On launch:
//   - latch mode; attack_cnt_o++ (saturating).
//   - hang_cnt <= hang value; gap_cnt <= gap value, both drawn from the current lfsr.
//   - lfsr steps once (Fibonacci x^16+x^14+x^13+x^11+1). The LFSR steps only on launch.
//   - $display "[time] [RS XXxYY-PORT] attack <mode>".
//  States:
//   IDLE:    no launch -> passthrough. EOP handshake: stay IDLE, gap_cnt-- if >0. Other fwd: -> PASS.
//            launch HANG: block this cycle (rx_o=0, cr_tx_o=0) -> HANG.
//            launch DROP: cr_tx_o=1, rx_o=0; tx_i&eop_tx_i -> IDLE, else -> DROP.
//            launch CORRUPT: first flit passes intact; EOP handshake -> IDLE, fwd -> CORRUPT, no fwd -> CORRUPT with head still pending.
//   PASS:    passthrough; EOP handshake -> IDLE, gap_cnt-- if >0.
//   HANG:    rx_o=0, cr_tx_o=0, data/eop_rx_o=0; hang_cnt-- each cycle; hang_cnt==1 -> PASS.
//            Head flit total blocked = hang+1 cycles. enable_i=0 -> PASS next cycle (abort).
//   DROP:    cr_tx_o=1, rx_o=0; each tx_i consumes a flit; tx_i&eop_tx_i -> IDLE. Ignores enable_i.
//   CORRUPT: passthrough with data_rx_o = data_tx_i ^ CORRUPT_MASK for every flit after the head; eop unchanged.
//            EOP handshake -> IDLE. Ignores enable_i.
//  - Attacked packets do not decrement gap_cnt.
//  - mode_i changes outside IDLE have no effect.
//  - gap_cnt and hang_cnt are 9-bit unsigned.
//  - cr_rx_i=0 stalls PASS/CORRUPT with no state change.
//  - tx_i=0 in IDLE keeps IDLE with no counter change.
// TESTING
//  T1 enable_i=0, 20 packets x4 flits, cr_rx_i=1 -> all 80 flits forwarded bit-exact, attack_cnt_o=0, attack_o=0.
//  T2 defaults, mode=1: packets 1-5 pass; packet 6 head held 29 cycles (cr_tx_o=0, rx_o=0); then forwarded intact. attack_cnt_o=1; packet 13 attacked next (gap 6).
//  T3 mode=2, 4-flit packets: packet 6 -> cr_tx_o=1 for 4 cycles, rx_o never asserted; downstream receives packets 1-5 then 7.
//  T4 mode=3, CORRUPT_MASK='hFF: packet 6 flit1 intact, flits 2-4 data ^ 'hFF, eop on flit 4 only.
//  T5 cr_rx_i toggled 0/1 mid-packet -> cr_tx_o mirrors cr_rx_i; gap_cnt moves only on EOP handshake; 1-flit packets each decrement gap.
//  T6 rst_ni low for 1 cycle during HANG -> outputs passthrough at once, gap_cnt=5, attack_cnt_o=0; enable_i=0 during HANG -> PASS next cycle.

Source files
------------

// File: rtl/link_fault_injector.sv
// Deterministic fault injector on one credit-based NoC link (tx side -> rx side).
// After a pseudo-random packet gap it stalls, swallows or corrupts one packet.
module link_fault_injector #(
    parameter int                     FLIT_WIDTH     = 32,
    parameter logic [15:0]            ADDRESS        = 16'h0,
    parameter                         PORT           = "",
    parameter logic [15:0]            SEED           = 16'hACE1,
    parameter int                     GAP_MIN        = 5,
    parameter int                     GAP_SPAN_LOG2  = 2,
    parameter int                     HANG_MIN       = 16,
    parameter int                     HANG_SPAN_LOG2 = 4,
    parameter logic [FLIT_WIDTH-1:0]  CORRUPT_MASK   = '1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic                  tx_i,
    input  logic [FLIT_WIDTH-1:0] data_tx_i,
    input  logic                  eop_tx_i,
    output logic                  cr_tx_o,
    output logic                  rx_o,
    output logic [FLIT_WIDTH-1:0] data_rx_o,
    output logic                  eop_rx_o,
    input  logic                  cr_rx_i,
    output logic                  attack_o,
    output logic [15:0]           attack_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_HANG,
        S_DROP,
        S_CORRUPT
    } state_t;

    localparam logic [7:0] GAP_MASK  = 8'((1 << GAP_SPAN_LOG2) - 1);
    localparam logic [7:0] HANG_MASK = 8'((1 << HANG_SPAN_LOG2) - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [8:0]  r_gapCnt;
    logic [8:0]  r_hangCnt;
    logic [15:0] r_lfsr;
    logic [15:0] r_attackCnt;
    logic        r_attacked;
    logic        r_headPending;

    logic        w_fwd;
    logic        w_eopHs;
    logic        w_launch;
    logic [8:0]  w_gapVal;
    logic [8:0]  w_hangVal;
    logic [15:0] w_lfsrNext;

    assign w_fwd    = tx_i & cr_rx_i;
    assign w_eopHs  = w_fwd & eop_tx_i;
    assign w_launch = (r_state == S_IDLE) & tx_i & enable_i & (mode_i != 2'd0) & (r_gapCnt == 9'd0);

    assign w_gapVal   = 9'(GAP_MIN)  + {1'b0, r_lfsr[7:0]  & GAP_MASK};
    assign w_hangVal  = 9'(HANG_MIN) + {1'b0, r_lfsr[15:8] & HANG_MASK};
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
    assign w_lfsrNext = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    assign attack_o     = (r_state == S_HANG) | (r_state == S_DROP) | (r_state == S_CORRUPT);
    assign attack_cnt_o = r_attackCnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    case (mode_i)
                        2'd1:    w_nextState = S_HANG;
                        2'd2:    w_nextState = eop_tx_i ? S_IDLE : S_DROP;
                        default: w_nextState = w_eopHs ? S_IDLE : S_CORRUPT;
                    endcase
                end else if (w_fwd && !eop_tx_i) begin
                    w_nextState = S_PASS;
                end
            end
            S_PASS:    if (w_eopHs) w_nextState = S_IDLE;
            S_HANG:    if (!enable_i || r_hangCnt <= 9'd1) w_nextState = S_PASS;
            S_DROP:    if (tx_i && eop_tx_i) w_nextState = S_IDLE;
            S_CORRUPT: if (w_eopHs) w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Blocked cycles drive zeros on the data side so a stalled flit never leaks downstream
    always_comb begin
        rx_o      = tx_i;
        data_rx_o = data_tx_i;
        eop_rx_o  = eop_tx_i;
        cr_tx_o   = cr_rx_i;
        case (r_state)
            S_IDLE: begin
                if (w_launch && mode_i == 2'd1) begin
                    rx_o      = 1'b0;
                    data_rx_o = '0;
                    eop_rx_o  = 1'b0;
                    cr_tx_o   = 1'b0;
                end else if (w_launch && mode_i == 2'd2) begin
                    rx_o      = 1'b0;
                    data_rx_o = '0;
                    eop_rx_o  = 1'b0;
                    cr_tx_o   = 1'b1;
                end
            end
            S_HANG: begin
                rx_o      = 1'b0;
                data_rx_o = '0;
                eop_rx_o  = 1'b0;
                cr_tx_o   = 1'b0;
            end
            S_DROP: begin
                rx_o      = 1'b0;
                data_rx_o = '0;
                eop_rx_o  = 1'b0;
                cr_tx_o   = 1'b1;
            end
            S_CORRUPT: begin
                if (!r_headPending) data_rx_o = data_tx_i ^ CORRUPT_MASK;
            end
            default: ;
        endcase
    end

    // r_attacked keeps a hung packet's trailing EOP in PASS from counting toward the gap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gapCnt      <= 9'(GAP_MIN);
            r_hangCnt     <= '0;
            r_lfsr        <= SEED;
            r_attackCnt   <= '0;
            r_attacked    <= 1'b0;
            r_headPending <= 1'b0;
        end else if (w_launch) begin
            if (r_attackCnt != 16'hFFFF) r_attackCnt <= r_attackCnt + 16'd1;
            r_hangCnt     <= w_hangVal;
            r_gapCnt      <= w_gapVal;
            r_lfsr        <= w_lfsrNext;
            r_attacked    <= (mode_i == 2'd1);
            r_headPending <= (mode_i == 2'd3) & ~w_fwd;
`ifndef SYNTHESIS
            $display("[%0t] [RS %02hx%02h-%s] attack %s", $time, ADDRESS[15:8], ADDRESS[7:0], PORT,
                     (mode_i == 2'd1) ? "HANG" : (mode_i == 2'd2) ? "DROP" : "CORRUPT");
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_eopHs && r_gapCnt != 9'd0) r_gapCnt <= r_gapCnt - 9'd1;
                end
                S_PASS: begin
                    if (w_eopHs) begin
                        if (r_attacked) r_attacked <= 1'b0;
                        else if (r_gapCnt != 9'd0) r_gapCnt <= r_gapCnt - 9'd1;
                    end
                end
                S_HANG: begin
                    r_hangCnt <= r_hangCnt - 9'd1;
                end
                S_CORRUPT: begin
                    if (w_fwd) r_headPending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_link_fault_injector.sv
// Scoreboard bench for link_fault_injector: packet-level reference model feeds an
// expected-flit queue; a negedge monitor pops and compares every downstream transfer.
module tb_link_fault_injector;

    localparam logic [31:0] MASK = 32'h0000_00FF;

    logic        clk_i     = 1'b0;
    logic        rst_ni    = 1'b0;
    logic        enable_i  = 1'b0;
    logic [1:0]  mode_i    = 2'd0;
    logic        tx_i      = 1'b0;
    logic [31:0] data_tx_i = '0;
    logic        eop_tx_i  = 1'b0;
    logic        cr_rx_i   = 1'b0;
    logic        cr_tx_o;
    logic        rx_o;
    logic [31:0] data_rx_o;
    logic        eop_rx_o;
    logic        attack_o;
    logic [15:0] attack_cnt_o;

    always #5 clk_i = ~clk_i;

    link_fault_injector #(
        .FLIT_WIDTH   (32),
        .ADDRESS      (16'h0102),
        .PORT         ("E"),
        .CORRUPT_MASK (MASK)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .tx_i         (tx_i),
        .data_tx_i    (data_tx_i),
        .eop_tx_i     (eop_tx_i),
        .cr_tx_o      (cr_tx_o),
        .rx_o         (rx_o),
        .data_rx_o    (data_rx_o),
        .eop_rx_o     (eop_rx_o),
        .cr_rx_i      (cr_rx_i),
        .attack_o     (attack_o),
        .attack_cnt_o (attack_cnt_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        eop;
    } flit_t;

    flit_t       expQ[$];
    flit_t       monFlit;
    int          checks = 0;
    int          passes = 0;
    bit          crRandom  = 0;
    logic        crHold    = 1'b0;
    bit          passCheck = 0;
    bit          checkHold = 0;
    logic [15:0] mLfsr;
    int          mGap;
    int          mCnt;
    logic [31:0] t6d[4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk_i) begin
        if (passCheck) begin
            checkOutput("passthrough cr_tx_o", {31'd0, cr_tx_o}, {31'd0, cr_rx_i});
            checkOutput("passthrough rx_o", {31'd0, rx_o}, {31'd0, tx_i});
        end
        if (rx_o && cr_rx_i) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected flit: got data %0h, expected no transfer", data_rx_o);
            end else begin
                monFlit = expQ.pop_front();
                checkOutput("flit data", data_rx_o, monFlit.data);
                checkOutput("flit eop", {31'd0, eop_rx_o}, {31'd0, monFlit.eop});
            end
        end
    end

    // Reference model: one decision per packet, taken when its head is offered
    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    task automatic modelReset();
        mLfsr = 16'hACE1;
        mGap  = 5;
        mCnt  = 0;
        expQ.delete();
    endtask

    task automatic modelPacket(input int len, input logic [31:0] d[4], output bit attacked, output int hold);
        flit_t f;
        attacked = enable_i && (mode_i != 2'd0) && (mGap == 0);
        hold = 0;
        if (attacked) begin
            if (mCnt < 65535) mCnt++;
            hold  = 16 + ((int'(mLfsr) / 256) % 16) + 1;
            mGap  = 5 + (int'(mLfsr) % 4);
            mLfsr = lfsrStep(mLfsr);
        end else if (mGap > 0) begin
            mGap--;
        end
        if (!(attacked && mode_i == 2'd2)) begin
            for (int i = 0; i < len; i++) begin
                f.data = (attacked && mode_i == 2'd3 && i > 0) ? (d[i] ^ MASK) : d[i];
                f.eop  = (i == len - 1);
                expQ.push_back(f);
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
        cr_rx_i = crRandom ? 1'($urandom_range(0, 1)) : crHold;
    endtask

    task automatic sendFlit(input logic [31:0] d, input logic e, input int abortAt, input bit isDrop, output int blocked);
        bit ok;
        tx_i      = 1'b1;
        data_tx_i = d;
        eop_tx_i  = e;
        blocked   = 0;
        ok        = 0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk_i);
            if (cr_tx_o) begin
                ok = 1;
                if (isDrop) checkOutput("drop rx_o low", {31'd0, rx_o}, 32'd0);
            end else begin
                blocked++;
                if (abortAt > 0 && blocked == abortAt) enable_i = 1'b0;
            end
            nextCycle();
        end
        if (!ok) begin
            checks++;
            $display("[TB] FAIL flit accept timeout: got no credit in 200 cycles, expected a credit");
        end
    endtask

    task automatic applyStimulus(input int len, input int abortAt);
        logic [31:0] d[4];
        bit          att;
        int          hold;
        int          blocked;
        logic [1:0]  pm;
        logic        savedEn;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        pm      = mode_i;
        savedEn = enable_i;
        modelPacket(len, d, att, hold);
        for (int f = 0; f < len; f++) begin
            sendFlit(d[f], (f == len - 1), (f == 0 && att && pm == 2'd1) ? abortAt : 0,
                     att && pm == 2'd2, blocked);
            if (f == 0 && att && pm == 2'd1 && checkHold)
                checkOutput("hang hold cycles", blocked, (abortAt > 0) ? abortAt : hold);
        end
        tx_i      = 1'b0;
        eop_tx_i  = 1'b0;
        data_tx_i = '0;
        enable_i  = savedEn;
    endtask

    task automatic doReset();
        tx_i   = 1'b0;
        rst_ni = 1'b0;
        nextCycle();
        nextCycle();
        rst_ni = 1'b1;
        modelReset();
    endtask

    task automatic endPhase(input string name);
        nextCycle();
        checkOutput({name, " scoreboard drained"}, expQ.size(), 32'd0);
        checkOutput({name, " attack_cnt_o"}, {16'd0, attack_cnt_o}, mCnt);
        checkOutput({name, " attack_o idle"}, {31'd0, attack_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit att;
        int hold;
        int blocked;

        // Reset state: counters clear, credit path is live even while reset is held
        #3;
        checkOutput("reset attack_cnt_o", {16'd0, attack_cnt_o}, 32'd0);
        checkOutput("reset attack_o", {31'd0, attack_o}, 32'd0);
        checkOutput("reset cr_tx_o low", {31'd0, cr_tx_o}, 32'd0);
        crHold  = 1'b1;
        cr_rx_i = 1'b1;
        #1;
        checkOutput("reset cr_tx_o high", {31'd0, cr_tx_o}, 32'd1);
        doReset();

        $display("[TB] T1 passthrough, enable_i=0");
        enable_i  = 1'b0;
        mode_i    = 2'd1;
        passCheck = 1;
        repeat (20) applyStimulus(4, 0);
        crRandom = 1;
        repeat (10) begin
            applyStimulus($urandom_range(1, 4), 0);
            repeat ($urandom_range(0, 2)) nextCycle();
        end
        crRandom  = 0;
        passCheck = 0;
        endPhase("T1");

        $display("[TB] T2 HANG");
        doReset();
        enable_i  = 1'b1;
        mode_i    = 2'd1;
        checkHold = 1;
        repeat (14) applyStimulus(4, 0);
        endPhase("T2");

        $display("[TB] T3 DROP");
        doReset();
        mode_i = 2'd2;
        repeat (14) applyStimulus(4, 0);
        endPhase("T3");

        $display("[TB] T4 CORRUPT");
        doReset();
        mode_i = 2'd3;
        repeat (14) applyStimulus(4, 0);
        endPhase("T4");

        $display("[TB] T5 random credits, lengths and modes");
        doReset();
        crRandom  = 1;
        checkHold = 0;
        repeat (80) begin
            mode_i   = 2'($urandom_range(0, 3));
            enable_i = ($urandom_range(0, 9) < 8);
            applyStimulus($urandom_range(1, 4), 0);
            repeat ($urandom_range(0, 2)) nextCycle();
        end
        crRandom = 0;
        endPhase("T5");

        $display("[TB] T6 reset and abort during HANG");
        doReset();
        enable_i  = 1'b1;
        mode_i    = 2'd1;
        checkHold = 1;
        repeat (5) applyStimulus(4, 0);
        for (int i = 0; i < 4; i++) t6d[i] = $urandom;
        tx_i      = 1'b1;
        data_tx_i = t6d[0];
        eop_tx_i  = 1'b0;
        repeat (6) nextCycle();
        checkOutput("T6 hang attack_o", {31'd0, attack_o}, 32'd1);
        checkOutput("T6 hang cr_tx_o", {31'd0, cr_tx_o}, 32'd0);
        checkOutput("T6 hang rx_o", {31'd0, rx_o}, 32'd0);
        checkOutput("T6 hang attack_cnt_o", {16'd0, attack_cnt_o}, 32'd1);
        modelReset();
        modelPacket(4, t6d, att, hold);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("T6 reset rx_o", {31'd0, rx_o}, 32'd1);
        checkOutput("T6 reset cr_tx_o", {31'd0, cr_tx_o}, 32'd1);
        checkOutput("T6 reset data_rx_o", data_rx_o, t6d[0]);
        checkOutput("T6 reset attack_o", {31'd0, attack_o}, 32'd0);
        checkOutput("T6 reset attack_cnt_o", {16'd0, attack_cnt_o}, 32'd0);
        nextCycle();
        rst_ni = 1'b1;
        for (int f = 1; f < 4; f++) sendFlit(t6d[f], (f == 3), 0, 0, blocked);
        tx_i     = 1'b0;
        eop_tx_i = 1'b0;
        repeat (5) applyStimulus(4, 0);
        repeat (9) applyStimulus(4, 5);
        endPhase("T6");

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
